// File: rtl/ultraram_bw.sv
// Byte-writable single-port-style UltraRAM wrapper with independent write and read ports and an output pipeline.
// Latency: a read accepted at edge T presents rd_valid/rd_data after edge T+1+NBPIPE (one array read register + NBPIPE+1 stages).
// Backpressure: rd_valid & ~out_ready freezes every read stage and drops rd_ready; writes are never stalled.
// Optional feature: define ULTRARAM_BW_PARITY_EN to store one even-parity bit per byte and report per-byte errors.
module ultraram_bw #(
  parameter int AWIDTH   = 12,
  parameter int DWIDTH   = 64,
  parameter int NBPIPE   = 2,
  parameter int RDW_MODE = 0
) (
  input  logic                  core_clk,
  input  logic                  resetn,
  input  logic                  wr_en,
  input  logic [DWIDTH/8-1:0]   wr_be,
  input  logic [AWIDTH-1:0]     wr_addr,
  input  logic [DWIDTH-1:0]     wr_data,
  input  logic                  wr_par_flip,
  input  logic                  rd_en,
  input  logic [AWIDTH-1:0]     rd_addr,
  output logic                  rd_ready,
  output logic                  rd_valid,
  output logic [DWIDTH-1:0]     rd_data,
  input  logic                  out_ready,
  output logic [DWIDTH/8-1:0]   rd_parity_err
);

  localparam int NB    = DWIDTH / 8;
  localparam int DEPTH = 1 << AWIDTH;
  // Array read register plus NBPIPE+1 further stages; the last one drives the outputs.
  localparam int NS    = NBPIPE + 2;

  // Storage array; contents survive reset.
  logic [DWIDTH-1:0] mem [DEPTH];

  // Flow control.
  logic stall;
  logic rd_acc;
  logic wr_do;

  assign stall    = rd_valid & ~out_ready;
  assign rd_ready = ~stall;
  assign rd_acc   = rd_en & ~stall;
  // Writes presented during reset are dropped.
  assign wr_do    = wr_en & resetn;

  // Read-port word after optional same-address write forwarding.
  logic [DWIDTH-1:0] rd_word;
  // Per-byte parity check result for rd_word.
  logic [NB-1:0]     rd_chk;

  // Pipeline state: data, parity error and valid per stage.
  logic [DWIDTH-1:0] d_q [NS];
  logic [NB-1:0]     e_q [NS];
  logic [NS-1:0]     v_q;

  // Byte-masked array write.
  always_ff @(posedge core_clk) begin
    if (wr_do) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) begin
          mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
        end
      end
    end
  end

  // Array read with optional byte-merge of a same-cycle write to the same address.
  always_comb begin
    rd_word = mem[rd_addr];
    if ((RDW_MODE != 0) && wr_do && (wr_addr == rd_addr)) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) begin
          rd_word[8*k +: 8] = wr_data[8*k +: 8];
        end
      end
    end
  end

`ifdef ULTRARAM_BW_PARITY_EN
  // One even-parity bit per byte, written under the same byte enables as the data.
  logic [NB-1:0] par_mem [DEPTH];
  logic [NB-1:0] wr_par;
  logic [NB-1:0] rd_par;

  // Parity of the incoming write; byte 0 can be deliberately corrupted.
  always_comb begin
    wr_par = '0;
    for (int k = 0; k < NB; k++) begin
      wr_par[k] = ^wr_data[8*k +: 8];
    end
    wr_par[0] = wr_par[0] ^ wr_par_flip;
  end

  // Parity array write, mirroring the data byte enables.
  always_ff @(posedge core_clk) begin
    if (wr_do) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) begin
          par_mem[wr_addr][k] <= wr_par[k];
        end
      end
    end
  end

  // Stored parity for the read, merged exactly like the data so errors follow RDW_MODE.
  always_comb begin
    rd_par = par_mem[rd_addr];
    if ((RDW_MODE != 0) && wr_do && (wr_addr == rd_addr)) begin
      for (int k = 0; k < NB; k++) begin
        if (wr_be[k]) begin
          rd_par[k] = wr_par[k];
        end
      end
    end
  end

  // Recompute parity on the read word and flag any byte that disagrees with storage.
  always_comb begin
    rd_chk = '0;
    for (int k = 0; k < NB; k++) begin
      rd_chk[k] = (^rd_word[8*k +: 8]) ^ rd_par[k];
    end
  end
`else
  // No parity storage: errors are never reported and the flip input has no effect.
  logic unused_par_flip;
  assign unused_par_flip = wr_par_flip;
  assign rd_chk          = '0;
`endif

  // Read pipeline: stage 0 is the array read register; all stages freeze together on stall.
  always_ff @(posedge core_clk) begin
    if (!resetn) begin
      v_q <= '0;
      for (int i = 0; i < NS; i++) begin
        d_q[i] <= '0;
        e_q[i] <= '0;
      end
    end else if (!stall) begin
      v_q    <= {v_q[NS-2:0], rd_acc};
      d_q[0] <= rd_word;
      e_q[0] <= rd_chk;
      for (int i = 1; i < NS; i++) begin
        d_q[i] <= d_q[i-1];
        e_q[i] <= e_q[i-1];
      end
    end
  end

  assign rd_valid      = v_q[NS-1];
  assign rd_data       = d_q[NS-1];
  assign rd_parity_err = e_q[NS-1];

endmodule

// File: doc/ultraram_bw.md
ULTRARAM_BW -- requirements
Module: ultraram_bw

Interface
- REQ-001 Parameters SHALL be (name, default, meaning):
  - AWIDTH, 12, address width; depth = 2^AWIDTH.
  - DWIDTH, 64, data width; SHALL be a multiple of 8.
  - NBPIPE, 2, output pipeline stages; SHALL be >= 1.
  - RDW_MODE, 0, same-address read-during-write result: 0 = old data, 1 = new (byte-merged) data.
- REQ-002 Ports SHALL be (name, direction, width, meaning):
  - core_clk, in, 1, clock; all logic on the rising edge.
  - resetn, in, 1, synchronous active-low reset.
  - wr_en, in, 1, write request.
  - wr_be, in, DWIDTH/8, byte write enables.
  - wr_addr, in, AWIDTH, write address.
  - wr_data, in, DWIDTH, write data.
  - wr_par_flip, in, 1, fault injection: invert the stored parity of byte 0 on this write.
  - rd_en, in, 1, read request.
  - rd_addr, in, AWIDTH, read address.
  - rd_ready, out, 1, read request accepted this cycle.
  - rd_valid, out, 1, rd_data holds a read result.
  - rd_data, out, DWIDTH, read data.
  - out_ready, in, 1, downstream accepts rd_data.
  - rd_parity_err, out, DWIDTH/8, per-byte parity error, aligned with rd_data.

Function
- REQ-003 A write SHALL occur when wr_en=1 at a rising edge.
  - Only bytes with wr_be[k]=1 are updated; all other bytes are unchanged.
  - Writes are never stalled.
  - wr_be=0 with wr_en=1 SHALL leave memory unchanged.
- REQ-004 Stall: stall = rd_valid & ~out_ready; rd_ready SHALL equal ~stall.
- REQ-005 A read SHALL be accepted when rd_en=1 and rd_ready=1.
  - rd_en while rd_ready=0 SHALL be ignored and not queued.
- REQ-006 Read latency: an accepted read at edge T SHALL present rd_valid=1 with its data after edge T+1+NBPIPE, provided no stall occurs in between.
- REQ-007 While stall=1, every pipeline stage (array read register, data and valid) SHALL hold its contents unchanged.
  - Results SHALL be neither lost nor duplicated.
  - Results SHALL leave in acceptance order.
- REQ-008 Without stalls, throughput SHALL be one read per cycle.
  - rd_valid SHALL deassert the cycle after the last result is consumed unless another result follows.
- REQ-009 Same-address read and write in the same cycle:
  - RDW_MODE=0: the read SHALL return pre-write data.
  - RDW_MODE=1: the read SHALL return the pre-write data with each byte k where wr_be[k]=1 replaced by wr_data byte k.
- REQ-010 Different-address simultaneous read and write SHALL not interact.
- REQ-011 A read of a never-written address SHALL return an undefined value; the bench SHALL not check it.

Reset
- REQ-012 While resetn=0 at an edge:
  - rd_valid=0, rd_data=0 and rd_parity_err=0.
  - All pipeline valid flags SHALL be cleared.
  - rd_ready SHALL be 1 (no result pending).
- REQ-013 Reads in flight when reset asserts SHALL be discarded.
  - Writes presented while resetn=0 SHALL be ignored.
  - Memory contents SHALL not be cleared by reset.
- REQ-014 The first edge with resetn=1 SHALL accept reads and writes normally.

Configuration
- REQ-015 Macro ULTRARAM_BW_PARITY_EN, defined:
  - One even-parity bit SHALL be stored per byte and updated with that byte's write enable.
  - wr_par_flip inverts the stored bit of byte 0 only.
  - The read path SHALL recompute parity and assert rd_parity_err[k] on mismatch.
  - rd_parity_err SHALL share the latency, stall and RDW_MODE behaviour of rd_data.
- REQ-016 Macro ULTRARAM_BW_PARITY_EN, undefined:
  - No parity storage SHALL exist.
  - rd_parity_err SHALL be constant 0 and wr_par_flip SHALL be ignored.
  - All other behaviour SHALL be identical to the defined case.

Verification
- REQ-017 Default parameters, out_ready=1: write 0x1122334455667788 to address 5 with wr_be=0xFF; read address 5 -> rd_valid one cycle only, 3 edges after acceptance, data 0x1122334455667788.
- REQ-018 Address 5 holds 0x1122334455667788; write 0xAAAAAAAAAAAAAAAA with wr_be=0x0F; read address 5 -> 0x11223344AAAAAAAA.
- REQ-019 Address 7 holds 0x0; same-cycle write 0xFF..FF (wr_be=0xFF) and read of address 7 -> RDW_MODE=0 returns 0x0, RDW_MODE=1 returns 0xFF..FF.
- REQ-020 Back-to-back reads of addresses 0..7 holding values 0..7, with out_ready low for 4 cycles mid-stream -> rd_ready low exactly while stalled; values 0..7 delivered in order, none dropped or duplicated.
- REQ-021 Reads of addresses 1 and 2 in flight, resetn pulsed low one cycle -> rd_valid=0 and rd_data=0 after reset; neither result appears; address 1 contents intact on re-read.
- REQ-022 ULTRARAM_BW_PARITY_EN defined: write address 3 with wr_par_flip=1, then read address 3 -> rd_parity_err=0x01; without the macro -> rd_parity_err=0x00.
